// File: rtl/pokemon_soc_pulse_outport.sv
// pokemon_soc_pulse_outport: Avalon-MM output port with timed XOR pulse mask and data-write strobe.
// Define POKEMON_SOC_PULSE_OUTPORT_BITSET_EN to enable the OUTSET/OUTCLEAR registers at offsets 4/5.
module pokemon_soc_pulse_outport #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             out_strobe,
  output logic             busy
);
`ifdef POKEMON_SOC_PULSE_OUTPORT_BITSET_EN
  localparam bit BITSET = 1'b1;
`else
  localparam bit BITSET = 1'b0;
`endif
  typedef enum logic {IDLE, PULSE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, mask_q, mask_d, wd;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [31:0] readdata_q, readdata_d;
  logic strobe_q, strobe_d;
  logic wr, set_wr, clr_wr, mask_wr;
  logic unused_wd;
  assign unused_wd = ^writedata;
  assign wd = writedata[WIDTH-1:0];
  assign wr = chipselect && !write_n;
  assign set_wr = BITSET && wr && address == 3'd4;
  assign clr_wr = BITSET && wr && address == 3'd5;
  // A mask write during a running pulse is dropped entirely, register included.
  assign mask_wr = wr && address == 3'd3 && state_q == IDLE;
  always_comb begin
    data_d = wr && address == 3'd0 ? wd :
             set_wr ? data_q | wd :
             clr_wr ? data_q & ~wd : data_q;
    mask_d = mask_wr ? wd : mask_q;
    len_d = wr && address == 3'd2 ? writedata[LEN_W-1:0] : len_q;
    strobe_d = (wr && address == 3'd0) || set_wr || clr_wr;
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (mask_wr && len_q != '0) begin
        state_d = PULSE;
        cnt_d = len_q;
      end
    end else begin
      cnt_d = cnt_q - LEN_W'(1);
      if (cnt_q == LEN_W'(1)) state_d = IDLE;
    end
    readdata_d = address == 3'd0 ? 32'(data_q) :
                 address == 3'd1 ? {31'd0, state_q == PULSE} :
                 address == 3'd2 ? 32'(len_q) :
                 address == 3'd3 ? 32'(mask_q) : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q <= '0;
      mask_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      readdata_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      mask_q <= mask_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      readdata_q <= readdata_d;
      strobe_q <= strobe_d;
    end
  end
  assign busy = state_q == PULSE;
  assign out_port = data_q ^ (busy ? mask_q : '0);
  assign out_strobe = strobe_q;
  assign readdata = readdata_q;
endmodule

// File: tb/tb_pokemon_soc_pulse_outport.sv
// tb_pokemon_soc_pulse_outport: directed bench for the pulse output port, default 8/16 configuration.
module tb_pokemon_soc_pulse_outport;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] address = '0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0] out_port;
  logic out_strobe, busy;
  int checks = 0;
  int errors = 0;
  logic [31:0] rv;
  pokemon_soc_pulse_outport dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .out_strobe(out_strobe), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    @(negedge clk);
    v = readdata;
  endtask
  initial begin
    #2;
    chk("rst_out", 32'(out_port), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobe", 32'(out_strobe), 0);
    chk("rst_rdata", readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr(0, 32'hA5);
    chk("data_out", 32'(out_port), 32'hA5);
    chk("data_strobe", 32'(out_strobe), 1);
    rd(0, rv);
    chk("data_strobe_off", 32'(out_strobe), 0);
    chk("data_read", rv, 32'h0000_00A5);
    wr(2, 3);
    wr(0, 32'h0F);
    chk("b2b_strobe1", 32'(out_strobe), 1);
    wr(0, 32'h0F);
    chk("b2b_strobe2", 32'(out_strobe), 1);
    wr(3, 32'hFF);
    chk("mask_no_strobe", 32'(out_strobe), 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pulse_busy%0d", i), 32'(busy), 1);
      chk($sformatf("pulse_out%0d", i), 32'(out_port), 32'hF0);
      @(negedge clk);
    end
    chk("pulse_end_busy", 32'(busy), 0);
    chk("pulse_end_out", 32'(out_port), 32'h0F);
    wr(2, 0);
    wr(3, 32'h01);
    chk("len0_busy", 32'(busy), 0);
    chk("len0_out", 32'(out_port), 32'h0F);
    rd(3, rv);
    chk("len0_mask", rv, 32'h01);
    wr(2, 10);
    wr(3, 32'h80);
    chk("p10_out", 32'(out_port), 32'h8F);
    wr(3, 32'h01);
    chk("p10_ign_busy", 32'(busy), 1);
    chk("p10_ign_out", 32'(out_port), 32'h8F);
    wr(0, 32'h00);
    chk("p10_data_out", 32'(out_port), 32'h80);
    wr(2, 1);
    chk("p10_len_busy", 32'(busy), 1);
    rd(3, rv);
    chk("p10_mask_read", rv, 32'h80);
    repeat (5) @(negedge clk);
    chk("p10_last_busy", 32'(busy), 1);
    chk("p10_last_out", 32'(out_port), 32'h80);
    @(negedge clk);
    chk("p10_end_busy", 32'(busy), 0);
    chk("p10_end_out", 32'(out_port), 32'h00);
    rd(2, rv);
    chk("p10_len_read", rv, 1);
    wr(2, 5);
    wr(0, 32'h0F);
    wr(3, 32'h3C);
    @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 1);
    chk("abort_pre_out", 32'(out_port), 32'h33);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_out", 32'(out_port), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdata", readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(1, rv);
    chk("abort_status", rv, 0);
    rd(2, rv);
    chk("abort_len", rv, 0);
    wr(0, 32'h0F);
    wr(4, 32'h30);
`ifdef POKEMON_SOC_PULSE_OUTPORT_BITSET_EN
    chk("outset_out", 32'(out_port), 32'h3F);
    chk("outset_strobe", 32'(out_strobe), 1);
`else
    chk("outset_out", 32'(out_port), 32'h0F);
    chk("outset_strobe", 32'(out_strobe), 0);
`endif
    @(negedge clk);
    wr(5, 32'h03);
`ifdef POKEMON_SOC_PULSE_OUTPORT_BITSET_EN
    chk("outclr_out", 32'(out_port), 32'h3C);
    chk("outclr_strobe", 32'(out_strobe), 1);
`else
    chk("outclr_out", 32'(out_port), 32'h0F);
    chk("outclr_strobe", 32'(out_strobe), 0);
`endif
    rd(4, rv);
    chk("outset_read", rv, 0);
    wr(6, 32'hFF);
    chk("rsvd_strobe", 32'(out_strobe), 0);
    rd(6, rv);
    chk("rsvd_read", rv, 0);
    rd(1, rv);
    chk("status_idle", rv, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pokemon_soc_pulse_outport.md
POKEMON_SOC_PULSE_OUTPORT -- requirements
Module: pokemon_soc_pulse_outport

Interface
REQ-001 Parameter WIDTH, default 8: width of out_port and of the DATA/MASK registers (1..32).
REQ-002 Parameter LEN_W, default 16: width of the PULSE_LEN register and the pulse counter (1..32).
REQ-003 The port list SHALL be:
- clk  input  1  clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  3  Avalon-MM word offset.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  driven output pins.
- out_strobe  output  1  one-cycle pulse after a DATA write.
- busy  output  1  high while a pulse is active.

Function
REQ-004 A write SHALL be accepted on a rising edge where chipselect=1 and write_n=0; registers SHALL update on that edge.
REQ-005 The register map SHALL be:
- 0 DATA, R/W, WIDTH bits.
- 1 STATUS, RO, bit0=busy.
- 2 PULSE_LEN, R/W, LEN_W bits.
- 3 PULSE_MASK, R/W, WIDTH bits; a write also triggers a pulse.
- 4 OUTSET, WO.
- 5 OUTCLEAR, WO.
- 6-7 reserved: read 0, writes ignored.
REQ-006 readdata SHALL be registered every cycle, regardless of chipselect, from the address-selected register zero-extended to 32 bits, giving one-cycle read latency; WO and reserved offsets SHALL read 0.
REQ-007 out_port SHALL equal DATA XOR (MASK if state=PULSE, else 0), derived combinationally from registered state.
REQ-008 The state machine SHALL have states IDLE and PULSE; busy=1 exactly in PULSE.
REQ-009 IDLE->PULSE SHALL occur on a PULSE_MASK write when PULSE_LEN!=0; the counter SHALL load PULSE_LEN on that edge.
REQ-010 In PULSE the counter SHALL decrement each edge; the edge at which counter=1 SHALL move to IDLE with counter=0; the pulse is therefore visible for exactly PULSE_LEN cycles.
REQ-011 A PULSE_MASK write with PULSE_LEN=0 SHALL update MASK only and SHALL NOT start a pulse.
REQ-012 A PULSE_MASK write while in PULSE SHALL be ignored entirely (MASK, counter and state unchanged).
REQ-013 A PULSE_LEN write while in PULSE SHALL update the register and SHALL NOT affect the running count.
REQ-014 A DATA write during PULSE SHALL take effect immediately; the mask continues to apply to the new DATA.
REQ-015 out_strobe SHALL be 1 for exactly the cycle after each accepted DATA, OUTSET or OUTCLEAR write, and 0 otherwise; back-to-back writes SHALL hold it high continuously.

Reset
REQ-016 On reset_n=0, asynchronously: DATA=0, MASK=0, PULSE_LEN=0, counter=0, state=IDLE, readdata=0, out_strobe=0. This forces out_port=0 and busy=0, including mid-pulse (the pulse is aborted).

Configuration
REQ-017 With macro POKEMON_SOC_PULSE_OUTPORT_BITSET_EN defined:
- OUTSET write: DATA |= writedata[WIDTH-1:0].
- OUTCLEAR write: DATA &= ~writedata[WIDTH-1:0].
REQ-018 Without the macro, offsets 4 and 5 SHALL behave as reserved (ignored, read 0, no strobe).

Verification
REQ-019 Reset, then write DATA=0xA5 -> next edge out_port=0xA5; out_strobe=1 for one cycle; read offset 0 returns 0x000000A5 one cycle later.
REQ-020 PULSE_LEN=3, DATA=0x0F, write PULSE_MASK=0xFF -> out_port=0xF0 and busy=1 for exactly 3 cycles, then 0x0F and busy=0.
REQ-021 PULSE_LEN=0, write PULSE_MASK=0x01 -> busy stays 0; out_port unchanged; offset 3 reads 0x01.
REQ-022 During a 10-cycle pulse with mask 0x80: write PULSE_MASK=0x01 -> ignored; write DATA=0x00 -> out_port=0x80 until pulse end, then 0x00.
REQ-023 Assert reset_n=0 at cycle 2 of a 5-cycle pulse -> out_port=0 and busy=0 immediately; after release, STATUS reads 0.
REQ-024 With BITSET_EN, DATA=0x0F: OUTSET 0x30 -> 0x3F; OUTCLEAR 0x03 -> 0x3C. Without BITSET_EN: DATA stays 0x0F and no strobe.
